// File: rtl/hex_gate_tester.sv
// In-circuit tester for six-channel single-input gate packages (inverter or buffer).
// Walks each channel through input levels 0 then 1 and accumulates pass/fail results.
module hex_gate_tester #(
   parameter int SETTLE = 1,
   parameter bit INVERT = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   output logic [5:0] dut_a,
   input  logic [5:0] dut_y,
   output logic       busy,
   output logic       done,
   output logic [7:0] test_count,
   output logic [7:0] error_count,
   output logic [5:0] fail_chan
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_DRIVE,
      ST_WAIT,
      ST_CHECK,
      ST_DONE
   } state_t;

   localparam logic [7:0] SETTLE_L = 8'(SETTLE);

   state_t     state_q, state_d;
   logic [2:0] chan_q, chan_d;
   logic       val_q, val_d;
   logic [7:0] settle_q, settle_d;
   logic [5:0] dut_a_q, dut_a_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;
   logic [7:0] test_q, test_d;
   logic [7:0] err_q, err_d;
   logic [5:0] fail_q, fail_d;
   logic       exp_bit;
   logic       mismatch;

   // x or z on the sampled output must count as a failure, hence the case inequality
   always_comb begin
      exp_bit  = INVERT ? ~val_q : val_q;
      mismatch = (dut_y[chan_q] !== exp_bit);
   end

   always_comb begin
      state_d  = state_q;
      chan_d   = chan_q;
      val_d    = val_q;
      settle_d = settle_q;
      dut_a_d  = dut_a_q;
      busy_d   = busy_q;
      done_d   = done_q;
      test_d   = test_q;
      err_d    = err_q;
      fail_d   = fail_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               test_d  = 8'd0;
               err_d   = 8'd0;
               fail_d  = 6'd0;
               dut_a_d = 6'd0;
               chan_d  = 3'd0;
               val_d   = 1'b0;
               busy_d  = 1'b1;
               done_d  = 1'b0;
               state_d = ST_DRIVE;
            end
         end
         ST_DRIVE: begin
            dut_a_d[chan_q] = val_q;
            settle_d        = SETTLE_L;
            state_d         = ST_WAIT;
         end
         ST_WAIT: begin
            settle_d = settle_q - 8'd1;
            if (settle_q <= 8'd1) begin
               state_d = ST_CHECK;
            end
         end
         ST_CHECK: begin
            if (test_q != 8'hFF) begin
               test_d = test_q + 8'd1;
            end
            if (mismatch) begin
               if (err_q != 8'hFF) begin
                  err_d = err_q + 8'd1;
               end
               fail_d[chan_q] = 1'b1;
            end
            if (!val_q) begin
               val_d   = 1'b1;
               state_d = ST_DRIVE;
            end else if (chan_q < 3'd5) begin
               chan_d  = chan_q + 3'd1;
               val_d   = 1'b0;
               state_d = ST_DRIVE;
            end else begin
               busy_d  = 1'b0;
               done_d  = 1'b1;
               state_d = ST_DONE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         chan_q   <= 3'd0;
         val_q    <= 1'b0;
         settle_q <= 8'd0;
         dut_a_q  <= 6'd0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         test_q   <= 8'd0;
         err_q    <= 8'd0;
         fail_q   <= 6'd0;
      end else begin
         state_q  <= state_d;
         chan_q   <= chan_d;
         val_q    <= val_d;
         settle_q <= settle_d;
         dut_a_q  <= dut_a_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         test_q   <= test_d;
         err_q    <= err_d;
         fail_q   <= fail_d;
      end
   end

   assign dut_a       = dut_a_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign test_count  = test_q;
   assign error_count = err_q;
   assign fail_chan   = fail_q;

endmodule

// File: tb/tb_hex_gate_tester.sv
// Bench for hex_gate_tester: three instances cover inverter/buffer expectation and two settle times.
// Expected run results come from a behavioural gate model and are queued when each run is started.
module tb_hex_gate_tester;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] start_v;
   logic [5:0] a_v [3];
   logic [5:0] y_v [3];
   logic [2:0] busy_v;
   logic [2:0] done_v;
   logic [7:0] tc_v [3];
   logic [7:0] ec_v [3];
   logic [5:0] fc_v [3];
   logic [5:0] stuck0;

   typedef struct {
      int         tests;
      int         errors;
      logic [5:0] fail;
      int         latency;
   } exp_t;

   exp_t sb [$];
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clk = ~clk;

   // Ideal inverters on every package; instance 0 can have pins stuck low
   assign y_v[0] = ~a_v[0] & ~stuck0;
   assign y_v[1] = ~a_v[1];
   assign y_v[2] = ~a_v[2];

   hex_gate_tester #(.SETTLE(1), .INVERT(1'b1)) u0 (
      .clk(clk), .rst(rst), .start(start_v[0]), .dut_a(a_v[0]), .dut_y(y_v[0]),
      .busy(busy_v[0]), .done(done_v[0]), .test_count(tc_v[0]),
      .error_count(ec_v[0]), .fail_chan(fc_v[0]));

   hex_gate_tester #(.SETTLE(1), .INVERT(1'b0)) u1 (
      .clk(clk), .rst(rst), .start(start_v[1]), .dut_a(a_v[1]), .dut_y(y_v[1]),
      .busy(busy_v[1]), .done(done_v[1]), .test_count(tc_v[1]),
      .error_count(ec_v[1]), .fail_chan(fc_v[1]));

   hex_gate_tester #(.SETTLE(3), .INVERT(1'b1)) u2 (
      .clk(clk), .rst(rst), .start(start_v[2]), .dut_a(a_v[2]), .dut_y(y_v[2]),
      .busy(busy_v[2]), .done(done_v[2]), .test_count(tc_v[2]),
      .error_count(ec_v[2]), .fail_chan(fc_v[2]));

   // Gate model: physical part is an inverter, tester expectation set by inv_param
   task automatic predict_run(input bit inv_param, input logic [5:0] stuck, input int settle);
      exp_t e;
      logic act, expv;
      e.tests   = 12;
      e.errors  = 0;
      e.fail    = 6'd0;
      e.latency = 12 * (settle + 2);
      for (int c = 0; c < 6; c++) begin
         for (int v = 0; v < 2; v++) begin
            act  = ~v[0] & ~stuck[c];
            expv = inv_param ? ~v[0] : v[0];
            if (act != expv) begin
               e.errors++;
               e.fail[c] = 1'b1;
            end
         end
      end
      sb.push_back(e);
   endtask

   task automatic accept_start(input int i);
      @(negedge clk);
      start_v[i] = 1'b1;
      @(posedge clk);
      #1;
      start_v[i] = 1'b0;
   endtask

   task automatic wait_done(input int i, inout int cycles, output bit timed_out);
      while (done_v[i] !== 1'b1 && cycles < 400) begin
         @(posedge clk);
         #1;
         cycles++;
      end
      timed_out = (done_v[i] !== 1'b1);
   endtask

   task automatic test_reset();
      rst     = 1'b1;
      start_v = 3'b000;
      stuck0  = 6'd0;
      repeat (2) @(posedge clk);
      #1;
      n_tests++; if (a_v[0] !== 6'd0) begin n_fail++; $display("[TB] FAIL reset_dut_a got %h want 00", a_v[0]); end
      n_tests++; if (busy_v !== 3'b000) begin n_fail++; $display("[TB] FAIL reset_busy got %b want 000", busy_v); end
      n_tests++; if (done_v !== 3'b000) begin n_fail++; $display("[TB] FAIL reset_done got %b want 000", done_v); end
      n_tests++; if (tc_v[0] !== 8'd0 || ec_v[0] !== 8'd0 || fc_v[0] !== 6'd0) begin
         n_fail++; $display("[TB] FAIL reset_counts got tc=%0d ec=%0d fc=%h want 0 0 00", tc_v[0], ec_v[0], fc_v[0]);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_ideal();
      exp_t e;
      int   cycles = 0;
      bit   to;
      predict_run(1'b1, stuck0, 1);
      accept_start(0);
      n_tests++; if (busy_v[0] !== 1'b1 || done_v[0] !== 1'b0) begin
         n_fail++; $display("[TB] FAIL t1_accept got busy=%b done=%b want 1 0", busy_v[0], done_v[0]);
      end
      wait_done(0, cycles, to);
      e = sb.pop_front();
      n_tests++; if (to) begin n_fail++; $display("[TB] FAIL t1_timeout got done=%b want 1", done_v[0]); end
      n_tests++; if (cycles != e.latency) begin n_fail++; $display("[TB] FAIL t1_latency got %0d want %0d", cycles, e.latency); end
      n_tests++; if (tc_v[0] !== 8'(e.tests)) begin n_fail++; $display("[TB] FAIL t1_test_count got %0d want %0d", tc_v[0], e.tests); end
      n_tests++; if (ec_v[0] !== 8'(e.errors)) begin n_fail++; $display("[TB] FAIL t1_error_count got %0d want %0d", ec_v[0], e.errors); end
      n_tests++; if (fc_v[0] !== e.fail) begin n_fail++; $display("[TB] FAIL t1_fail_chan got %h want %h", fc_v[0], e.fail); end
      n_tests++; if (a_v[0] !== 6'h3F || busy_v[0] !== 1'b0) begin
         n_fail++; $display("[TB] FAIL t1_end_state got dut_a=%h busy=%b want 3f 0", a_v[0], busy_v[0]);
      end
      repeat (3) @(posedge clk);
      #1;
      n_tests++; if (done_v[0] !== 1'b1 || tc_v[0] !== 8'(e.tests)) begin
         n_fail++; $display("[TB] FAIL t1_done_hold got done=%b tc=%0d want 1 %0d", done_v[0], tc_v[0], e.tests);
      end
   endtask

   task automatic test_stuck();
      exp_t e;
      int   cycles = 0;
      bit   to;
      stuck0 = 6'b001000;
      predict_run(1'b1, stuck0, 1);
      accept_start(0);
      wait_done(0, cycles, to);
      e = sb.pop_front();
      n_tests++; if (to) begin n_fail++; $display("[TB] FAIL t2_timeout got done=%b want 1", done_v[0]); end
      n_tests++; if (tc_v[0] !== 8'(e.tests)) begin n_fail++; $display("[TB] FAIL t2_test_count got %0d want %0d", tc_v[0], e.tests); end
      n_tests++; if (ec_v[0] !== 8'(e.errors)) begin n_fail++; $display("[TB] FAIL t2_error_count got %0d want %0d", ec_v[0], e.errors); end
      n_tests++; if (fc_v[0] !== e.fail) begin n_fail++; $display("[TB] FAIL t2_fail_chan got %b want %b", fc_v[0], e.fail); end
   endtask

   task automatic test_restart_from_done();
      exp_t e;
      int   cycles = 0;
      bit   to;
      stuck0 = 6'd0;
      predict_run(1'b1, stuck0, 1);
      accept_start(0);
      n_tests++; if (tc_v[0] !== 8'd0 || ec_v[0] !== 8'd0 || fc_v[0] !== 6'd0 || a_v[0] !== 6'd0) begin
         n_fail++; $display("[TB] FAIL t6_clear got tc=%0d ec=%0d fc=%h a=%h want 0 0 00 00", tc_v[0], ec_v[0], fc_v[0], a_v[0]);
      end
      wait_done(0, cycles, to);
      e = sb.pop_front();
      n_tests++; if (to) begin n_fail++; $display("[TB] FAIL t6_timeout got done=%b want 1", done_v[0]); end
      n_tests++; if (ec_v[0] !== 8'(e.errors)) begin n_fail++; $display("[TB] FAIL t6_error_count got %0d want %0d", ec_v[0], e.errors); end
      n_tests++; if (fc_v[0] !== e.fail) begin n_fail++; $display("[TB] FAIL t6_fail_chan got %h want %h", fc_v[0], e.fail); end
   endtask

   task automatic test_invert0();
      exp_t e;
      int   cycles = 0;
      bit   to;
      predict_run(1'b0, 6'd0, 1);
      accept_start(1);
      wait_done(1, cycles, to);
      e = sb.pop_front();
      n_tests++; if (to) begin n_fail++; $display("[TB] FAIL t3_timeout got done=%b want 1", done_v[1]); end
      n_tests++; if (ec_v[1] !== 8'(e.errors)) begin n_fail++; $display("[TB] FAIL t3_error_count got %0d want %0d", ec_v[1], e.errors); end
      n_tests++; if (fc_v[1] !== e.fail) begin n_fail++; $display("[TB] FAIL t3_fail_chan got %h want %h", fc_v[1], e.fail); end
   endtask

   task automatic test_ignore_start();
      exp_t e;
      int   cycles = 0;
      bit   to;
      predict_run(1'b1, 6'd0, 3);
      accept_start(2);
      repeat (5) begin
         @(posedge clk);
         #1;
         cycles++;
      end
      @(negedge clk);
      start_v[2] = 1'b1;
      @(posedge clk);
      #1;
      cycles++;
      start_v[2] = 1'b0;
      n_tests++; if (busy_v[2] !== 1'b1 || tc_v[2] !== 8'd1) begin
         n_fail++; $display("[TB] FAIL t4_not_restarted got busy=%b tc=%0d want 1 1", busy_v[2], tc_v[2]);
      end
      wait_done(2, cycles, to);
      e = sb.pop_front();
      n_tests++; if (to) begin n_fail++; $display("[TB] FAIL t4_timeout got done=%b want 1", done_v[2]); end
      n_tests++; if (cycles != e.latency) begin n_fail++; $display("[TB] FAIL t4_latency got %0d want %0d", cycles, e.latency); end
      n_tests++; if (tc_v[2] !== 8'(e.tests) || ec_v[2] !== 8'(e.errors)) begin
         n_fail++; $display("[TB] FAIL t4_counts got tc=%0d ec=%0d want %0d %0d", tc_v[2], ec_v[2], e.tests, e.errors);
      end
   endtask

   task automatic test_async_reset();
      exp_t e;
      int   cycles = 0;
      bit   to;
      accept_start(0);
      while (tc_v[0] !== 8'd4 && cycles < 100) begin
         @(posedge clk);
         #1;
         cycles++;
      end
      n_tests++; if (tc_v[0] !== 8'd4) begin n_fail++; $display("[TB] FAIL t5_reach_ch2 got tc=%0d want 4", tc_v[0]); end
      #3;
      rst = 1'b1;
      #1;
      n_tests++; if (a_v[0] !== 6'd0 || busy_v[0] !== 1'b0 || done_v[0] !== 1'b0) begin
         n_fail++; $display("[TB] FAIL t5_async_outputs got a=%h busy=%b done=%b want 00 0 0", a_v[0], busy_v[0], done_v[0]);
      end
      n_tests++; if (tc_v[0] !== 8'd0 || ec_v[0] !== 8'd0 || fc_v[0] !== 6'd0) begin
         n_fail++; $display("[TB] FAIL t5_async_counts got tc=%0d ec=%0d fc=%h want 0 0 00", tc_v[0], ec_v[0], fc_v[0]);
      end
      @(negedge clk);
      rst = 1'b0;
      predict_run(1'b1, stuck0, 1);
      accept_start(0);
      cycles = 0;
      wait_done(0, cycles, to);
      e = sb.pop_front();
      n_tests++; if (to || cycles != e.latency) begin
         n_fail++; $display("[TB] FAIL t5_rerun_latency got %0d timeout=%b want %0d", cycles, to, e.latency);
      end
      n_tests++; if (tc_v[0] !== 8'(e.tests) || ec_v[0] !== 8'(e.errors) || fc_v[0] !== e.fail) begin
         n_fail++; $display("[TB] FAIL t5_rerun_counts got tc=%0d ec=%0d fc=%h want %0d %0d %h",
                            tc_v[0], ec_v[0], fc_v[0], e.tests, e.errors, e.fail);
      end
   endtask

   initial begin
      test_reset();
      test_ideal();
      test_stuck();
      test_restart_from_done();
      test_invert0();
      test_ignore_start();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
